// File: rtl/hdmi_i2c_pkg.sv
// rtl/hdmi_i2c_pkg.sv - shared states, response codes and byte-controller command encodings
package hdmi_i2c_pkg;

  typedef enum logic [2:0] {
    IDLE, ADDR, REG, WDATA, RADDR, RDATA, ERRSTOP, RESP
  } state_t;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_NACK    = 2'd1;
  localparam logic [1:0] ERR_ARB     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  // Command bit order: {start, stop, read, write, ack}
  localparam logic [4:0] CMD_NONE        = 5'b00000;
  localparam logic [4:0] CMD_START_WRITE = 5'b10010;
  localparam logic [4:0] CMD_WRITE       = 5'b00010;
  localparam logic [4:0] CMD_WRITE_STOP  = 5'b01010;
  localparam logic [4:0] CMD_READ_NACK   = 5'b01101;
  localparam logic [4:0] CMD_STOP        = 5'b01000;

  function automatic logic [4:0] cmd_for(state_t s);
    case (s)
      ADDR:    cmd_for = CMD_START_WRITE;
      REG:     cmd_for = CMD_WRITE;
      WDATA:   cmd_for = CMD_WRITE_STOP;
      RADDR:   cmd_for = CMD_START_WRITE;
      RDATA:   cmd_for = CMD_READ_NACK;
      ERRSTOP: cmd_for = CMD_STOP;
      default: cmd_for = CMD_NONE;
    endcase
  endfunction

endpackage

// File: rtl/hdmi_i2c_watchdog.sv
// rtl/hdmi_i2c_watchdog.sv - per-command cycle counter; expired flags the last allowed cycle
module hdmi_i2c_watchdog #(
  parameter logic [15:0] LIMIT = 16'd50000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [15:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= 16'd0;
    end else if (enable && count != 16'hFFFF) begin
      count <= count + 16'd1;
    end
  end

  // Count is 0 in the first cycle a command is visible, so this fires in cycle LIMIT-1
  assign expired = enable && (count == LIMIT - 16'd1);

endmodule

// File: rtl/hdmi_i2c_txn.sv
// rtl/hdmi_i2c_txn.sv - I2C register read/write sequencer; I2C_RETRY_EN enables NACK retries
module hdmi_i2c_txn
  import hdmi_i2c_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000,
  parameter int          RETRY_MAX      = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rd,
  input  logic [7:0] req_dev,
  input  logic [7:0] req_reg,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [1:0] rsp_err,
  output logic [7:0] rsp_rdata,
  output logic       i2c_start,
  output logic       i2c_stop,
  output logic       i2c_read,
  output logic       i2c_write,
  output logic       i2c_ack_out,
  output logic [7:0] i2c_din,
  input  logic       i2c_done,
  input  logic       i2c_ack_in,
  input  logic       i2c_al,
  input  logic [7:0] i2c_dout
);

  state_t     state_q, state_d;
  logic       issued_q, issued_d;
  logic [4:0] cmd_q, cmd_d;
  logic [7:0] din_q, din_d, din_sel;
  logic [1:0] err_q, err_d;
  logic [7:0] rdata_q, rdata_d;
  logic       rd_q, rd_d;
  logic [6:0] dev_q, dev_d;
  logic [7:0] reg_q, reg_d;
  logic [7:0] wdata_q, wdata_d;
  logic       expired;
`ifdef I2C_RETRY_EN
  logic [3:0] retry_q, retry_d;
`endif

  hdmi_i2c_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (!issued_q),
    .enable  (issued_q),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      issued_q <= 1'b0;
      cmd_q    <= CMD_NONE;
      din_q    <= 8'd0;
      err_q    <= ERR_OK;
      rdata_q  <= 8'd0;
      rd_q     <= 1'b0;
      dev_q    <= 7'd0;
      reg_q    <= 8'd0;
      wdata_q  <= 8'd0;
`ifdef I2C_RETRY_EN
      retry_q  <= 4'd0;
`endif
    end else begin
      state_q  <= state_d;
      issued_q <= issued_d;
      cmd_q    <= cmd_d;
      din_q    <= din_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      rd_q     <= rd_d;
      dev_q    <= dev_d;
      reg_q    <= reg_d;
      wdata_q  <= wdata_d;
`ifdef I2C_RETRY_EN
      retry_q  <= retry_d;
`endif
    end
  end

  always_comb begin
    din_sel = 8'd0;
    case (state_q)
      ADDR:    din_sel = {dev_q, 1'b0};
      REG:     din_sel = reg_q;
      WDATA:   din_sel = wdata_q;
      RADDR:   din_sel = {dev_q, 1'b1};
      default: din_sel = 8'd0;
    endcase
  end

  // issued_q splits each command state into an issue cycle and a wait-for-ack phase;
  // the cycle after ack is always a cleared (all-zero) cycle before the next issue.
  always_comb begin
    state_d  = state_q;
    issued_d = issued_q;
    cmd_d    = cmd_q;
    din_d    = din_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    rd_d     = rd_q;
    dev_d    = dev_q;
    reg_d    = reg_q;
    wdata_d  = wdata_q;
`ifdef I2C_RETRY_EN
    retry_d  = retry_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          rd_d     = req_rd;
          dev_d    = req_dev[7:1];
          reg_d    = req_reg;
          wdata_d  = req_wdata;
          err_d    = ERR_OK;
          issued_d = 1'b0;
          state_d  = ADDR;
`ifdef I2C_RETRY_EN
          retry_d  = 4'd0;
`endif
        end
      end
      RESP: state_d = IDLE;
      default: begin
        if (i2c_al) begin
          cmd_d    = CMD_NONE;
          din_d    = 8'd0;
          issued_d = 1'b0;
          err_d    = ERR_ARB;
          state_d  = RESP;
        end else if (!issued_q) begin
          cmd_d    = cmd_for(state_q);
          din_d    = din_sel;
          issued_d = 1'b1;
        end else if (i2c_done) begin
          cmd_d    = CMD_NONE;
          din_d    = 8'd0;
          issued_d = 1'b0;
          case (state_q)
            ADDR:  state_d = i2c_ack_in ? ERRSTOP : REG;
            REG:   state_d = i2c_ack_in ? ERRSTOP : (rd_q ? RADDR : WDATA);
            RADDR: state_d = i2c_ack_in ? ERRSTOP : RDATA;
            WDATA: begin
              err_d   = i2c_ack_in ? ERR_NACK : ERR_OK;
              state_d = RESP;
            end
            RDATA: begin
              rdata_d = i2c_dout;
              err_d   = ERR_OK;
              state_d = RESP;
            end
            ERRSTOP: begin
`ifdef I2C_RETRY_EN
              if (int'(retry_q) < RETRY_MAX) begin
                retry_d = retry_q + 4'd1;
                state_d = ADDR;
              end else begin
                err_d   = ERR_NACK;
                state_d = RESP;
              end
`else
              err_d   = ERR_NACK;
              state_d = RESP;
`endif
            end
            default: state_d = IDLE;
          endcase
        end else if (expired) begin
          cmd_d    = CMD_NONE;
          din_d    = 8'd0;
          issued_d = 1'b0;
          err_d    = ERR_TIMEOUT;
          state_d  = RESP;
        end
      end
    endcase
  end

  assign req_ready   = (state_q == IDLE);
  assign rsp_valid   = (state_q == RESP);
  assign rsp_err     = err_q;
  assign rsp_rdata   = rdata_q;
  assign i2c_start   = cmd_q[4];
  assign i2c_stop    = cmd_q[3];
  assign i2c_read    = cmd_q[2];
  assign i2c_write   = cmd_q[1];
  assign i2c_ack_out = cmd_q[0];
  assign i2c_din     = din_q;

endmodule

// File: tb/tb_hdmi_i2c_txn.sv
// tb/tb_hdmi_i2c_txn.sv - directed self-checking bench for hdmi_i2c_txn
module tb_hdmi_i2c_txn;

  logic       clk, reset;
  logic       req_valid, req_ready, req_rd;
  logic [7:0] req_dev, req_reg, req_wdata;
  logic       rsp_valid;
  logic [1:0] rsp_err;
  logic [7:0] rsp_rdata;
  logic       i2c_start, i2c_stop, i2c_read, i2c_write, i2c_ack_out;
  logic [7:0] i2c_din;
  logic       i2c_done, i2c_ack_in, i2c_al;
  logic [7:0] i2c_dout;
  logic [4:0] cmd_obs;

  int checks = 0;
  int failures = 0;

  hdmi_i2c_txn #(.TIMEOUT_CYCLES(16'd100), .RETRY_MAX(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_rd(req_rd),
    .req_dev(req_dev), .req_reg(req_reg), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata),
    .i2c_start(i2c_start), .i2c_stop(i2c_stop), .i2c_read(i2c_read),
    .i2c_write(i2c_write), .i2c_ack_out(i2c_ack_out), .i2c_din(i2c_din),
    .i2c_done(i2c_done), .i2c_ack_in(i2c_ack_in), .i2c_al(i2c_al),
    .i2c_dout(i2c_dout)
  );

  assign cmd_obs = {i2c_start, i2c_stop, i2c_read, i2c_write, i2c_ack_out};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cmd(input string tag, output logic ok);
    int n = 0;
    while (cmd_obs == 5'd0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    ok = (cmd_obs != 5'd0);
    if (!ok) begin
      checks++;
      failures++;
      $error("FAIL %s observed=no_command expected=command", tag);
    end
  endtask

  task automatic serve(input string tag, input logic [4:0] ecmd, input logic [7:0] edin,
                       input logic nack, input logic al, input logic [7:0] dout);
    logic ok;
    wait_cmd(tag, ok);
    if (ok) begin
      chk({tag, "_cmd"}, 32'(cmd_obs), 32'(ecmd));
      chk({tag, "_din"}, 32'(i2c_din), 32'(edin));
      i2c_done = 1'b1; i2c_ack_in = nack; i2c_al = al; i2c_dout = dout;
      @(negedge clk);
      i2c_done = 1'b0; i2c_ack_in = 1'b0; i2c_al = 1'b0; i2c_dout = 8'h00;
      chk({tag, "_clr"}, 32'(cmd_obs), 32'd0);
    end
  endtask

  task automatic request(input logic rd, input logic [7:0] dev, input logic [7:0] rg,
                         input logic [7:0] wd);
    req_rd = rd; req_dev = dev; req_reg = rg; req_wdata = wd; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; req_rd = ~rd; req_dev = 8'hFF; req_reg = 8'hEE; req_wdata = 8'hDD;
    chk("busy_ready", 32'(req_ready), 32'd0);
  endtask

  task automatic wait_rsp(input string tag, input logic [1:0] eerr, input logic chk_rd,
                          input logic [7:0] erd);
    int n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid) begin
      checks++;
      failures++;
      $error("FAIL %s observed=no_rsp_valid expected=rsp_valid", tag);
    end else begin
      chk({tag, "_err"}, 32'(rsp_err), 32'(eerr));
      if (chk_rd) chk({tag, "_rdata"}, 32'(rsp_rdata), 32'(erd));
      @(negedge clk);
      chk({tag, "_pulse"}, 32'(rsp_valid), 32'd0);
      chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    logic ok;
    reset = 1'b1; req_valid = 1'b0; req_rd = 1'b0; req_dev = 8'h00; req_reg = 8'h00;
    req_wdata = 8'h00; i2c_done = 1'b0; i2c_ack_in = 1'b0; i2c_al = 1'b0; i2c_dout = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_cmd", 32'(cmd_obs), 32'd0);
    chk("rst_din", 32'(i2c_din), 32'd0);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd1);
    reset = 1'b0;
    @(negedge clk);

    // register write, all ACKs
    request(1'b0, 8'h72, 8'h41, 8'h10);
    serve("wr_addr", 5'b10010, 8'h72, 1'b0, 1'b0, 8'h00);
    serve("wr_reg", 5'b00010, 8'h41, 1'b0, 1'b0, 8'h00);
    serve("wr_data", 5'b01010, 8'h10, 1'b0, 1'b0, 8'h00);
    wait_rsp("wr_rsp", 2'd0, 1'b0, 8'h00);

    // register read returning C0
    request(1'b1, 8'h72, 8'h96, 8'h00);
    serve("rd_addr", 5'b10010, 8'h72, 1'b0, 1'b0, 8'h00);
    serve("rd_reg", 5'b00010, 8'h96, 1'b0, 1'b0, 8'h00);
    serve("rd_raddr", 5'b10010, 8'h73, 1'b0, 1'b0, 8'h00);
    serve("rd_data", 5'b01101, 8'h00, 1'b0, 1'b0, 8'hC0);
    wait_rsp("rd_rsp", 2'd0, 1'b1, 8'hC0);

    // NACK on address byte; dev bit0 set must be ignored
    request(1'b0, 8'h73, 8'h01, 8'h02);
`ifdef I2C_RETRY_EN
    for (int a = 0; a < 3; a++) begin
      serve("nk_addr", 5'b10010, 8'h72, 1'b1, 1'b0, 8'h00);
      serve("nk_stop", 5'b01000, 8'h00, 1'b0, 1'b0, 8'h00);
    end
`else
    serve("nk_addr", 5'b10010, 8'h72, 1'b1, 1'b0, 8'h00);
    serve("nk_stop", 5'b01000, 8'h00, 1'b0, 1'b0, 8'h00);
`endif
    wait_rsp("nk_rsp", 2'd1, 1'b0, 8'h00);

    // NACK on write data: reported without an extra stop
    request(1'b0, 8'h72, 8'h05, 8'h5A);
    serve("wn_addr", 5'b10010, 8'h72, 1'b0, 1'b0, 8'h00);
    serve("wn_reg", 5'b00010, 8'h05, 1'b0, 1'b0, 8'h00);
    serve("wn_data", 5'b01010, 8'h5A, 1'b1, 1'b0, 8'h00);
    chk("wn_nostop", 32'(cmd_obs), 32'd0);
    wait_rsp("wn_rsp", 2'd1, 1'b0, 8'h00);

    // arbitration lost together with done during REG
    request(1'b1, 8'h72, 8'h10, 8'h00);
    serve("al_addr", 5'b10010, 8'h72, 1'b0, 1'b0, 8'h00);
    serve("al_reg", 5'b00010, 8'h10, 1'b0, 1'b1, 8'h00);
    chk("al_nostop", 32'(i2c_stop), 32'd0);
    wait_rsp("al_rsp", 2'd2, 1'b0, 8'h00);

    // done withheld: abort exactly 100 cycles after issue
    request(1'b0, 8'h72, 8'h20, 8'h00);
    wait_cmd("to_wait", ok);
    if (ok) begin
      repeat (99) @(negedge clk);
      chk("to_held", 32'(cmd_obs), 32'b10010);
      @(negedge clk);
      chk("to_clr", 32'(cmd_obs), 32'd0);
      chk("to_valid", 32'(rsp_valid), 32'd1);
      chk("to_err", 32'(rsp_err), 32'd3);
      @(negedge clk);
      chk("to_pulse", 32'(rsp_valid), 32'd0);
    end

    // reset while RDATA command outstanding
    request(1'b1, 8'h72, 8'h33, 8'h00);
    serve("rs_addr", 5'b10010, 8'h72, 1'b0, 1'b0, 8'h00);
    serve("rs_reg", 5'b00010, 8'h33, 1'b0, 1'b0, 8'h00);
    serve("rs_raddr", 5'b10010, 8'h73, 1'b0, 1'b0, 8'h00);
    wait_cmd("rs_wait", ok);
    chk("rs_rdcmd", 32'(cmd_obs), 32'b01101);
    reset = 1'b1;
    @(negedge clk);
    chk("rs_cmd", 32'(cmd_obs), 32'd0);
    chk("rs_din", 32'(i2c_din), 32'd0);
    chk("rs_valid", 32'(rsp_valid), 32'd0);
    chk("rs_err", 32'(rsp_err), 32'd0);
    chk("rs_rdata", 32'(rsp_rdata), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rs_ready", 32'(req_ready), 32'd1);
    chk("rs_idle_cmd", 32'(cmd_obs), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
